clk_gate_ctrl: RTL and testbench

//  Multi-channel clock-gating controller: one gated clock per downstream domain (RegFile, ALU, UART, ...).

---
 rtl/clk_gate_pkg.sv | 30 +++
 rtl/clk_gate_ctrl_if.sv | 22 ++
 rtl/clk_gate_cell.sv | 19 +
 rtl/clk_gate_ctrl.sv | 140 ++++++++++++++
 tb/tb_clk_gate_ctrl.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/clk_gate_pkg.sv
// Shared types and helpers for the multi-channel clock-gating controller.
package clk_gate_pkg;

    localparam int MAX_CH = 16;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_WAKE = 2'd1,
        ST_ON   = 2'd2,
        ST_HOLD = 2'd3
    } ch_state_e;

    // Counter must hold the larger of the two reload values (IDLE-1, WAKE-1).
    function automatic int cnt_width(input int idle, input int wake);
        int m;
        m = (idle > wake) ? idle : wake;
        return $clog2(m + 1);
    endfunction

    // Number of set bits in a (zero-extended) channel vector.
    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] c;
        c = 5'd0;
        for (int k = 0; k < 16; k++) begin
            c = c + {4'd0, v[k]};
        end
        return c;
    endfunction

endpackage

// File: rtl/clk_gate_ctrl_if.sv
// Request/acknowledge bundle between the system controller and the gating block.
interface clk_gate_ctrl_if #(
    parameter int NUM_CH = 4
);
    logic                         test_en;
    logic [NUM_CH-1:0]            ch_req;
    logic [NUM_CH-1:0]            ch_act;
    logic [NUM_CH-1:0]            gated_clk;
    logic [NUM_CH-1:0]            ch_ack;
    logic [NUM_CH-1:0]            ch_en;
    logic [$clog2(NUM_CH+1)-1:0]  on_count;

    modport master (
        output test_en, ch_req, ch_act,
        input  gated_clk, ch_ack, ch_en, on_count
    );

    modport slave (
        input  test_en, ch_req, ch_act,
        output gated_clk, ch_ack, ch_en, on_count
    );
endinterface

// File: rtl/clk_gate_cell.sv
// Glitch-free clock gate: low-phase transparent latch followed by an AND.
// Synthesis maps this onto an integrated clock-gating cell.
module clk_gate_cell (
    input  logic clk,
    input  logic clk_en,
    input  logic test_en,
    output logic gated_clk
);
    logic latch_q;

    // Enable may only change while clk is low, so the AND never sees a partial pulse.
    always_latch begin
        if (!clk) begin
            latch_q <= clk_en | test_en;
        end
    end

    assign gated_clk = clk & latch_q;
endmodule

// File: rtl/clk_gate_ctrl.sv
// Multi-channel clock-gating controller: per-channel wake/settle/idle FSM,
// registered enable/ack outputs, enabled-channel count and one gate cell per channel.
module clk_gate_ctrl
    import clk_gate_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int IDLE_CYCLES = 8,
    parameter int WAKE_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    clk_gate_ctrl_if.slave  bus
);
    localparam int CNT_W   = cnt_width(IDLE_CYCLES, WAKE_CYCLES);
    localparam int COUNT_W = $clog2(NUM_CH + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0] IDLE_LOAD = (IDLE_CYCLES > 0) ? CNT_W'(IDLE_CYCLES - 1) : CNT_ZERO;

    logic [NUM_CH-1:0]  en_s;
    logic [NUM_CH-1:0]  ack_s;
    logic [NUM_CH-1:0]  ch_en_r;
    logic [NUM_CH-1:0]  ch_ack_r;
    logic [NUM_CH-1:0]  gated_s;
    logic [COUNT_W-1:0] on_count_r;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ch_state_e        state_r;
        ch_state_e        state_s;
        logic [CNT_W-1:0] cnt_r;
        logic [CNT_W-1:0] cnt_s;
        logic             en_nxt_s;
        logic             ack_nxt_s;

        // Channel state and wake/idle counter.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_r <= ST_OFF;
                cnt_r   <= CNT_ZERO;
            end else begin
                state_r <= state_s;
                cnt_r   <= cnt_s;
            end
        end

        // Next state: wake on request, abort wake if request drops, idle-timeout back to off.
        always_comb begin
            state_s = state_r;
            cnt_s   = cnt_r;
            case (state_r)
                ST_OFF: begin
                    if (bus.ch_req[i]) begin
                        state_s = ST_WAKE;
                        cnt_s   = WAKE_LOAD;
                    end else begin
                        state_s = ST_OFF;
                    end
                end
                ST_WAKE: begin
                    if (!bus.ch_req[i]) begin
                        state_s = ST_OFF;
                    end else if (cnt_r == CNT_ZERO) begin
                        state_s = ST_ON;
                    end else begin
                        cnt_s = cnt_r - CNT_ONE;
                    end
                end
                ST_ON: begin
                    // Activity keeps the channel on even when the request has dropped.
                    if (!bus.ch_req[i] && !bus.ch_act[i]) begin
                        if (IDLE_CYCLES == 0) begin
                            state_s = ST_OFF;
                        end else begin
                            state_s = ST_HOLD;
                            cnt_s   = IDLE_LOAD;
                        end
                    end else begin
                        state_s = ST_ON;
                    end
                end
                ST_HOLD: begin
                    if (bus.ch_req[i] || bus.ch_act[i]) begin
                        state_s = ST_ON;
                    end else if (cnt_r == CNT_ZERO) begin
                        state_s = ST_OFF;
                    end else begin
                        cnt_s = cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    state_s = ST_OFF;
                    cnt_s   = CNT_ZERO;
                end
            endcase
        end

        // Output decode of the next state; registered below so EN/ACK track the state register.
        always_comb begin
            en_nxt_s  = 1'b0;
            ack_nxt_s = 1'b0;
            case (state_s)
                ST_OFF:  begin en_nxt_s = 1'b0; ack_nxt_s = 1'b0; end
                ST_WAKE: begin en_nxt_s = 1'b1; ack_nxt_s = 1'b0; end
                ST_ON:   begin en_nxt_s = 1'b1; ack_nxt_s = 1'b1; end
                ST_HOLD: begin en_nxt_s = 1'b1; ack_nxt_s = 1'b1; end
                default: begin en_nxt_s = 1'b0; ack_nxt_s = 1'b0; end
            endcase
        end

        assign en_s[i]  = en_nxt_s;
        assign ack_s[i] = ack_nxt_s;

        clk_gate_cell u_gate (
            .clk       (clk),
            .clk_en    (ch_en_r[i]),
            .test_en   (bus.test_en),
            .gated_clk (gated_s[i])
        );
    end

    // Registered enables, acks and enabled-channel count, all updated on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ch_en_r    <= {NUM_CH{1'b0}};
            ch_ack_r   <= {NUM_CH{1'b0}};
            on_count_r <= {COUNT_W{1'b0}};
        end else begin
            ch_en_r    <= en_s;
            ch_ack_r   <= ack_s;
            on_count_r <= COUNT_W'(popcount16(16'(en_s)));
        end
    end

    assign bus.ch_en     = ch_en_r;
    assign bus.ch_ack    = ch_ack_r;
    assign bus.on_count  = on_count_r;
    assign bus.gated_clk = gated_s;
endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Self-checking bench for clk_gate_ctrl (NUM_CH=4, IDLE_CYCLES=8, WAKE_CYCLES=2).
module tb_clk_gate_ctrl;
    localparam int NCH  = 4;
    localparam int IDLE = 8;
    localparam int WAKE = 2;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    clk_gate_ctrl_if #(.NUM_CH(NCH)) bus ();

    clk_gate_ctrl #(.NUM_CH(NCH), .IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: a channel is powered from the request edge; it is settled once it
    // has seen WAKE further request edges; once settled it powers down after more than
    // IDLE consecutive edges with neither request nor activity.
    int powered [NCH];
    int age     [NCH];
    int quiet   [NCH];

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            powered[c] = 0; age[c] = 0; quiet[c] = 0;
        end
    endfunction

    function automatic void model_edge(input logic [3:0] req, input logic [3:0] act);
        for (int c = 0; c < NCH; c++) begin
            if (powered[c] == 0) begin
                if (req[c]) begin
                    powered[c] = 1; age[c] = 0; quiet[c] = 0;
                end
            end else if (age[c] < WAKE) begin
                if (!req[c]) powered[c] = 0;
                else         age[c] = age[c] + 1;
            end else begin
                if (req[c] || act[c]) quiet[c] = 0;
                else                  quiet[c] = quiet[c] + 1;
                if (quiet[c] > IDLE) powered[c] = 0;
            end
        end
    endfunction

    function automatic logic [3:0] m_en();
        logic [3:0] v;
        for (int c = 0; c < NCH; c++) v[c] = (powered[c] != 0);
        return v;
    endfunction

    function automatic logic [3:0] m_ack();
        logic [3:0] v;
        for (int c = 0; c < NCH; c++) v[c] = (powered[c] != 0) && (age[c] >= WAKE);
        return v;
    endfunction

    function automatic logic [2:0] m_count();
        int n;
        n = 0;
        for (int c = 0; c < NCH; c++) n += (powered[c] != 0) ? 1 : 0;
        return 3'(n);
    endfunction

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Called in the clock-low phase: drive inputs, take one edge, compare, return in the low phase.
    task automatic step(input logic [3:0] req, input logic [3:0] act, input logic te);
        logic [3:0] prev_en;
        bus.ch_req  = req;
        bus.ch_act  = act;
        bus.test_en = te;
        prev_en     = m_en();
        @(posedge clk);
        model_edge(req, act);
        #2;
        check("ch_en",    8'(bus.ch_en),    8'(m_en()));
        check("ch_ack",   8'(bus.ch_ack),   8'(m_ack()));
        check("on_count", 8'(bus.on_count), 8'(m_count()));
        check("gated_hi", 8'(bus.gated_clk), 8'(prev_en | {4{te}}));
        #5;
        check("gated_lo", 8'(bus.gated_clk), 8'h00);
    endtask

    typedef struct {
        logic [3:0] req;
        logic [3:0] act;
        logic       te;
        logic [3:0] en;
        logic [3:0] ack;
        logic [2:0] cnt;
    } vec_t;

    vec_t tbl [7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] rreq;
        logic [3:0] ract;
        logic       rte;

        // Ch0 wakes and settles; ch1 wakes for one edge and aborts.
        tbl[0] = '{req: 4'b0000, act: 4'b0000, te: 1'b0, en: 4'b0000, ack: 4'b0000, cnt: 3'd0};
        tbl[1] = '{req: 4'b0001, act: 4'b0000, te: 1'b0, en: 4'b0001, ack: 4'b0000, cnt: 3'd1};
        tbl[2] = '{req: 4'b0001, act: 4'b0000, te: 1'b0, en: 4'b0001, ack: 4'b0000, cnt: 3'd1};
        tbl[3] = '{req: 4'b0001, act: 4'b0000, te: 1'b0, en: 4'b0001, ack: 4'b0001, cnt: 3'd1};
        tbl[4] = '{req: 4'b0011, act: 4'b0100, te: 1'b0, en: 4'b0011, ack: 4'b0001, cnt: 3'd2};
        tbl[5] = '{req: 4'b0001, act: 4'b0000, te: 1'b0, en: 4'b0001, ack: 4'b0001, cnt: 3'd1};
        tbl[6] = '{req: 4'b0001, act: 4'b0010, te: 1'b0, en: 4'b0001, ack: 4'b0001, cnt: 3'd1};

        rst         = 1'b0;
        bus.ch_req  = 4'b0000;
        bus.ch_act  = 4'b0000;
        bus.test_en = 1'b0;
        model_reset();
        #12;
        check("rst_en",    8'(bus.ch_en),     8'h00);
        check("rst_ack",   8'(bus.ch_ack),    8'h00);
        check("rst_count", 8'(bus.on_count),  8'h00);
        check("rst_gated", 8'(bus.gated_clk), 8'h00);
        rst = 1'b1;

        // Idle after reset: nothing wakes.
        for (int k = 0; k < 20; k++) step(4'b0000, 4'b0000, 1'b0);

        // Wake and wake-abort table.
        for (int k = 0; k < 7; k++) begin
            step(tbl[k].req, tbl[k].act, tbl[k].te);
            check("tbl_en",    8'(bus.ch_en),    8'(tbl[k].en));
            check("tbl_ack",   8'(bus.ch_ack),   8'(tbl[k].ack));
            check("tbl_count", 8'(bus.on_count), 8'(tbl[k].cnt));
        end

        // Request drops, activity mid-hold restarts the full idle window.
        for (int k = 0; k < 4; k++) begin
            step(4'b0000, 4'b0000, 1'b0);
            check("hold_ack", 8'(bus.ch_ack[0]), 8'h01);
        end
        step(4'b0000, 4'b0001, 1'b0);
        check("act_ack", 8'(bus.ch_ack[0]), 8'h01);
        for (int k = 0; k < IDLE; k++) begin
            step(4'b0000, 4'b0000, 1'b0);
            check("idle_en",  8'(bus.ch_en[0]),  8'h01);
            check("idle_ack", 8'(bus.ch_ack[0]), 8'h01);
        end
        step(4'b0000, 4'b0000, 1'b0);
        check("off_en",  8'(bus.ch_en[0]),  8'h00);
        check("off_ack", 8'(bus.ch_ack[0]), 8'h00);

        // Scan override: all gates open, controller state untouched.
        for (int k = 0; k < 3; k++) begin
            step(4'b0000, 4'b0000, 1'b1);
            check("te_en",    8'(bus.ch_en),    8'h00);
            check("te_count", 8'(bus.on_count), 8'h00);
        end
        step(4'b0000, 4'b0000, 1'b0);

        // All channels on, then reset pulsed in the clock-high phase.
        for (int k = 0; k < 3; k++) step(4'b1111, 4'b0000, 1'b0);
        check("all_ack",   8'(bus.ch_ack),   8'h0f);
        check("all_count", 8'(bus.on_count), 8'h04);
        @(posedge clk);
        model_edge(4'b1111, 4'b0000);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("arst_en",    8'(bus.ch_en),    8'h00);
        check("arst_ack",   8'(bus.ch_ack),   8'h00);
        check("arst_count", 8'(bus.on_count), 8'h00);
        @(negedge clk);
        #1;
        check("arst_gated_lo", 8'(bus.gated_clk), 8'h00);
        @(posedge clk);
        #2;
        check("arst_gated_hi", 8'(bus.gated_clk), 8'h00);
        #5;
        bus.ch_req = 4'b0000;
        rst = 1'b1;

        // Randomised traffic against the model.
        rreq = 4'b0000;
        for (int k = 0; k < 400; k++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 7) == 0) rreq[c] = ~rreq[c];
                ract[c] = ($urandom_range(0, 5) == 0);
            end
            rte = ($urandom_range(0, 15) == 0);
            step(rreq, ract, rte);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
